timer_array: RTL



---
 rtl/timer_pkg.sv | 51 +++++
 rtl/timer_array_if.sv | 21 ++
 rtl/timer_channel.sv | 152 +++++++++++++++
 rtl/timer_array.sv | 65 ++++++
 4 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for the timer_array block: channel mode encoding,
//   per-channel register offsets, CTRL field layout, and a couple of helpers
//   for packing the CTRL register and sizing the channel index.
// -----------------------------------------------------------------------------
package timer_pkg;

    // Channel operating modes. Encoding 3 is not named: it behaves as ONESHOT.
    typedef enum logic [1:0] {
        ONESHOT = 2'd0,
        RELOAD  = 2'd1,
        SQUARE  = 2'd2
    } mode_e;

    // Register offsets within a channel (low two address bits).
    localparam logic [1:0] REG_LOAD   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL field positions and widths.
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_W  = 2;
    localparam int CTRL_IE      = 3;
    localparam int CTRL_PSC_LO  = 8;
    localparam int CTRL_PSC_W   = 8;

    // STATUS field positions.
    localparam int STATUS_DONE  = 0;

    // Stored CTRL contents; only the implemented fields are kept.
    typedef struct packed {
        logic [CTRL_PSC_W-1:0] psc;
        logic                  ie;
        mode_e                 mode;
        logic                  en;
    } ctrl_t;

    // CTRL as seen on the bus: unimplemented bits [7:4] read as zero.
    function automatic logic [15:0] ctrl_word(input ctrl_t c);
        return {c.psc, 4'b0000, c.ie, c.mode, c.en};
    endfunction

    // Width of the channel index field; at least one bit even for one channel.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_array_if.sv
// -----------------------------------------------------------------------------
// timer_array_if
//   MIO-side register bus for timer_array.
//     we    : write strobe, sampled at rising clk
//     addr  : {channel, reg[1:0]}
//     wdata : write data
//     rdata : combinational read data for addr
//   master drives the strobe/address/data, slave returns rdata.
// -----------------------------------------------------------------------------
interface timer_array_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 32
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  wdata;
    logic [CNT_W-1:0]  rdata;

    modport master (output we, addr, wdata, input  rdata);
    modport slave  (input  we, addr, wdata, output rdata);
endinterface

// File: rtl/timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
//   One timer channel: LOAD/CTRL/COUNT/STATUS registers, prescaler, down
//   counter and output waveform logic.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     we_i       : write strobe already qualified for this channel
//     reg_i      : register offset within the channel
//     wdata_i    : write data
//     rdata_o    : combinational read data for reg_i
//     ch_out_o   : channel output waveform
//     irq_o      : done & IE
// -----------------------------------------------------------------------------
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [1:0]       reg_i,
    input  logic [CNT_W-1:0] wdata_i,
    output logic [CNT_W-1:0] rdata_o,
    output logic             ch_out_o,
    output logic             irq_o
);

    logic [CNT_W-1:0]      load_q,  load_d;
    ctrl_t                 ctrl_q,  ctrl_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CTRL_PSC_W-1:0] pre_q,   pre_d;
    logic                  done_q,  done_d;
    // Output is the OR of a held level (one-shot / square) and a one-clock
    // pulse (auto-reload), so the pulse drops by itself without disturbing
    // the level.
    logic                  level_q, level_d;
    logic                  pulse_q, pulse_d;

    logic load_we;
    logic ctrl_we;
    logic status_we;
    logic tick;
    logic terminal;

    assign load_we   = we_i && (reg_i == REG_LOAD);
    assign ctrl_we   = we_i && (reg_i == REG_CTRL);
    assign status_we = we_i && (reg_i == REG_STATUS);

    // A CTRL write in the same cycle takes precedence over counting, so the
    // tick is suppressed: a restart starts cleanly and a stop holds state.
    assign tick     = ctrl_q.en && (pre_q == ctrl_q.psc) && !ctrl_we;
    assign terminal = tick && (count_q == '0);

    // NOTE: every signal written here gets its default first; otherwise a
    // path that skips an assignment would infer a latch.
    always_comb begin
        load_d  = load_q;
        ctrl_d  = ctrl_q;
        count_d = count_q;
        pre_d   = pre_q;
        done_d  = done_q;
        level_d = level_q;
        pulse_d = 1'b0;

        // New LOAD only takes effect at the next reload or restart.
        if (load_we) begin
            load_d = wdata_i;
        end

        if (ctrl_we) begin
            ctrl_d.en   = wdata_i[CTRL_EN];
            ctrl_d.mode = mode_e'(wdata_i[CTRL_MODE_LO +: CTRL_MODE_W]);
            ctrl_d.ie   = wdata_i[CTRL_IE];
            ctrl_d.psc  = wdata_i[CTRL_PSC_LO +: CTRL_PSC_W];
            // Enabling write (re)starts the channel; disabling write freezes
            // COUNT and the output level.
            if (wdata_i[CTRL_EN]) begin
                count_d = load_q;
                pre_d   = '0;
                level_d = 1'b0;
            end
        end else if (ctrl_q.en) begin
            pre_d = tick ? '0 : pre_q + CTRL_PSC_W'(1);
            if (tick) begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    unique case (ctrl_q.mode)
                        RELOAD: begin
                            count_d = load_q;
                            pulse_d = 1'b1;
                        end
                        SQUARE: begin
                            count_d = load_q;
                            level_d = ~level_q;
                        end
                        default: begin
                            // One-shot (and encoding 3): stop with output high.
                            ctrl_d.en = 1'b0;
                            level_d   = 1'b1;
                        end
                    endcase
                end
            end
        end

        // Clear first, then set: a terminal event in the same cycle wins.
        if (status_we && wdata_i[STATUS_DONE]) begin
            done_d = 1'b0;
        end
        if (terminal) begin
            done_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_q  <= '0;
            ctrl_q  <= '0;
            count_q <= '0;
            pre_q   <= '0;
            done_q  <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            load_q  <= load_d;
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (reg_i)
            REG_LOAD:   rdata_o = load_q;
            REG_CTRL:   rdata_o[15:0] = ctrl_word(ctrl_q);
            REG_COUNT:  rdata_o = count_q;
            default:    rdata_o[STATUS_DONE] = done_q;
        endcase
    end

    assign ch_out_o = level_q | pulse_q;
    assign irq_o    = done_q & ctrl_q.ie;

endmodule

// File: rtl/timer_array.sv
// -----------------------------------------------------------------------------
// timer_array
//   Memory-mapped array of NUM_CH down-counter/timer channels on the MIO bus.
//   Holds the address decode, the read mux and the interrupt OR; each channel
//   lives in timer_channel.
//   Ports:
//     clk, rst : single clock, synchronous active-high reset
//     bus      : register bus (slave side), addr = {channel, reg[1:0]}
//     ch_out   : per-channel output waveform
//     irq      : OR over channels of (done & IE)
//   Channel indices at or above NUM_CH read as zero and ignore writes.
// -----------------------------------------------------------------------------
module timer_array
    import timer_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    timer_array_if.slave      bus,
    output logic [NUM_CH-1:0] ch_out,
    output logic              irq
);

    localparam int CH_W   = ch_bits(NUM_CH);
    localparam int ADDR_W = CH_W + 2;

    logic [CH_W-1:0]  ch_sel;
    logic [1:0]       reg_sel;
    logic [CNT_W-1:0] ch_rdata [NUM_CH];
    logic [NUM_CH-1:0] ch_irq;

    assign ch_sel  = bus.addr[ADDR_W-1:2];
    assign reg_sel = bus.addr[1:0];

    // Only an exact index match strobes a channel, so writes to
    // unpopulated indices fall through untouched.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .we_i     (bus.we && (ch_sel == CH_W'(i))),
            .reg_i    (reg_sel),
            .wdata_i  (bus.wdata),
            .rdata_o  (ch_rdata[i]),
            .ch_out_o (ch_out[i]),
            .irq_o    (ch_irq[i])
        );
    end

    always_comb begin
        bus.rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                bus.rdata = ch_rdata[i];
            end
        end
    end

    assign irq = |ch_irq;

endmodule
